// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the memory-side blocks.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;
endpackage

// File: rtl/mem_bridge_watchdog.sv
// Access watchdog: 8-bit up-counter whose terminal count marks the last
// cycle a physical access may stay outstanding.
module mem_bridge_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_terminal = (r_count == LAST_COUNT);
endmodule

// File: rtl/mem_bridge.sv
// LC-3b CPU memory port to physical memory bridge: registers each request,
// steers byte stores onto the right lane and bounds accesses with a watchdog.
module mem_bridge
    import lc3b_types::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    input  lc3b_mem_wmask mem_byte_enable,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          pmem_read,
    output logic          pmem_write,
    output logic [15:0]   pmem_address,
    output logic [15:0]   pmem_wdata,
    output logic [1:0]    pmem_byte_enable,
    input  logic          pmem_resp,
    input  logic [15:0]   pmem_rdata,
    output logic          bus_error
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic          w_timeout;
    logic          w_wd_en;
    logic          w_wd_terminal;

    logic          r_is_write;
    logic [15:0]   r_addr;
    lc3b_word      r_wdata;
    lc3b_mem_wmask r_mask;
    lc3b_word      r_rdata;
    logic          r_bus_error;

    lc3b_word      w_lat_wdata;
    lc3b_mem_wmask w_lat_mask;

    mem_bridge_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_enable  (w_wd_en),
        .o_terminal(w_wd_terminal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A response and the watchdog expiry in the same cycle resolve as a normal completion.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        w_wd_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_write || mem_read) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end
            end
            ISSUE: begin
                w_wd_en = 1'b1;
                if (pmem_resp) begin
                    w_next = RESP;
                end else if (w_wd_terminal) begin
                    w_timeout = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Byte stores always carry their data in [7:0]; the address LSB picks the lane.
    always_comb begin
        w_lat_wdata = mem_wdata;
        w_lat_mask  = mem_byte_enable;
        if (mem_byte_enable == 2'b01 || mem_byte_enable == 2'b10) begin
            if (mem_address[0]) begin
                w_lat_wdata = {mem_wdata[7:0], 8'h00};
                w_lat_mask  = 2'b10;
            end else begin
                w_lat_wdata = {8'h00, mem_wdata[7:0]};
                w_lat_mask  = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_write <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_mask     <= 2'b00;
        end else if (w_accept) begin
            r_is_write <= mem_write;
            r_addr     <= {mem_address[15:1], 1'b0};
            r_wdata    <= w_lat_wdata;
            r_mask     <= w_lat_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata     <= 16'h0000;
            r_bus_error <= 1'b0;
        end else if (r_state == ISSUE) begin
            if (pmem_resp) begin
                if (!r_is_write) begin
                    r_rdata <= pmem_rdata;
                end
            end else if (w_timeout) begin
                r_bus_error <= 1'b1;
                if (!r_is_write) begin
                    r_rdata <= 16'h0000;
                end
            end
        end
    end

    assign pmem_read        = (r_state == ISSUE) && !r_is_write;
    assign pmem_write       = (r_state == ISSUE) && r_is_write;
    assign pmem_address     = r_addr;
    assign pmem_wdata       = r_wdata;
    assign pmem_byte_enable = r_mask;
    assign mem_resp         = (r_state == RESP);
    assign mem_rdata        = r_rdata;
    assign bus_error        = r_bus_error;
endmodule
